// File: rtl/fifo_stream_pkg.sv
// Shared definitions for FIFO-to-stream adapters: read-side state encoding
// and the depth of the latency-absorbing buffer.
package fifo_stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } stream_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered register buffer: absorbs one cycle of upstream read
// latency while the downstream sink stalls. Head is always the oldest entry.
module skid_buf2
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0]      mem_reg [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] wr_sel;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;

    // One write strobe per entry, steered by the tail pointer.
    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = push & (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Push and pop together leave the occupancy unchanged.
    always_comb begin
        occ_next = occ_reg + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_next;
        end
    end

    assign occ  = occ_reg;
    assign head = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fifo_read_streamer.sv
// Drains a FIFO read port into a valid/ready stream grouped into bursts of
// BURST_LEN words, keeping at most two words buffered or in flight.
module fifo_read_streamer
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int BURST_LEN = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 rd_clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 empty_i,
    input  logic [WIDTH-1:0]     rdata_i,
    output logic                 rd_en_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] burst_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);

    stream_state_e        state_reg;
    stream_state_e        state_next;
    logic                 inflight_reg;
    logic [CNT_WIDTH-1:0] word_cnt_reg;
    logic [CNT_WIDTH-1:0] burst_cnt_reg;
    logic [1:0]           occ;
    logic [WIDTH-1:0]     head;
    logic                 pop;
    logic [2:0]           pending;

    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (rd_clk_i),
        .srst      (rst_i),
        .push      (inflight_reg),
        .push_data (rdata_i),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign m_valid_o = (occ != 2'd0);
    assign m_data_o  = head;
    assign m_last_o  = m_valid_o & (word_cnt_reg == LAST_IDX);
    assign pop       = m_valid_o & m_ready_i;
    assign busy_o    = m_valid_o | inflight_reg;

    // Reads are gated by the next state so enable changes act in the same
    // cycle; a pop this cycle frees one slot for a new read.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (enable_i)  state_next = ST_RUN;
            ST_RUN:  if (!enable_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        pending = {1'b0, occ} + {2'b00, inflight_reg};
        rd_en_o = (state_next == ST_RUN) && !empty_i
                  && (pending < (3'd2 + {2'b00, pop}));
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            inflight_reg  <= 1'b0;
            word_cnt_reg  <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd_en_o;
            if (pop) begin
                if (m_last_o) begin
                    word_cnt_reg  <= '0;
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
                end else begin
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign burst_cnt_o = burst_cnt_reg;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed bench for fifo_read_streamer: a FIFO model feeds the DUT and a
// stream model checks every cycle; each test adds literal expectations.
module tb_fifo_read_streamer;

    localparam int W  = 4;
    localparam int BL = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          empty_i = 1'b1;
    logic [W-1:0]  rdata_i = '0;
    logic          rd_en_o;
    logic          m_valid_o;
    logic [W-1:0]  m_data_o;
    logic          m_last_o;
    logic          m_ready_i = 1'b0;
    logic          busy_o;
    logic [CW-1:0] burst_cnt_o;

    fifo_read_streamer #(
        .WIDTH     (W),
        .BURST_LEN (BL),
        .CNT_WIDTH (CW)
    ) dut (
        .rd_clk_i    (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .empty_i     (empty_i),
        .rdata_i     (rdata_i),
        .rd_en_o     (rd_en_o),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o),
        .burst_cnt_o (burst_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_pulses = 0;
    bit toggle_mode = 1'b0;

    logic [W-1:0] fifo_q[$];   // written, not yet read
    logic [W-1:0] exp_q[$];    // read by DUT, not yet popped
    int           exp_cyc[$];  // cycle in which each of those reads was issued
    logic [W-1:0] dlv_q[$];    // popped words in order
    logic [W-1:0] lastw_q[$];  // popped words that carried m_last_o
    int           word_idx = 0;
    int           bursts = 0;
    bit           hold_v = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO with one-cycle registered read latency; empty can be forced on
    // alternate cycles to exercise the empty boundary.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en_o) rd_pulses++;
        if (rd_en_o && !empty_i) begin
            rdata_i <= fifo_q[0];
            if (!rst_i) begin
                exp_q.push_back(fifo_q[0]);
                exp_cyc.push_back(cyc);
            end
            void'(fifo_q.pop_front());
        end else begin
            rdata_i <= W'($urandom);
        end
        empty_i <= (fifo_q.size() == 0) || (toggle_mode && !empty_i);
    end

    // Stream model: words leave in read order, valid two cycles after the
    // read, at most two outstanding, last on every BL-th pop.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            exp_cyc.delete();
            word_idx = 0;
            bursts = 0;
            hold_v = 1'b0;
        end else begin
            bit pop_now;
            bit head_ready;
            bit rd_exp;
            int pend;
            pop_now = m_valid_o && m_ready_i;
            pend = exp_q.size();
            head_ready = (pend > 0) && (cyc >= exp_cyc[0] + 2);
            rd_exp = enable_i && !empty_i && ((pend - int'(pop_now)) < 2);
            check("valid", 32'(m_valid_o), 32'(head_ready));
            check("busy", 32'(busy_o), 32'(pend > 0));
            check("burst_cnt", 32'(burst_cnt_o), 32'(bursts[7:0]));
            check("rd_en", 32'(rd_en_o), 32'(rd_exp));
            check("last", 32'(m_last_o), 32'(m_valid_o && (word_idx == BL - 1)));
            if (m_valid_o && pend > 0) check("data", 32'(m_data_o), 32'(exp_q[0]));
            if (hold_v && m_valid_o) begin
                check("hold_data", 32'(m_data_o), 32'(hold_d));
                check("hold_last", 32'(m_last_o), 32'(hold_l));
            end
            if (pop_now && pend > 0) begin
                dlv_q.push_back(m_data_o);
                if (m_last_o) lastw_q.push_back(m_data_o);
                void'(exp_q.pop_front());
                void'(exp_cyc.pop_front());
                word_idx++;
                if (word_idx == BL) begin
                    word_idx = 0;
                    bursts++;
                end
            end
            hold_v = m_valid_o && !pop_now;
            hold_d = m_data_o;
            hold_l = m_last_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        rst_i = 1'b1;
        enable_i = 1'b0;
        m_ready_i = 1'b0;
        toggle_mode = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        dlv_q.delete();
        lastw_q.delete();
    endtask

    task automatic wait_dlv(input int n, input int bound, output int used);
        used = 0;
        while (dlv_q.size() < n && used < bound) begin
            tick();
            used++;
        end
        check("dlv_count", 32'(dlv_q.size()), 32'(n));
    endtask

    initial begin
        int t_rd;
        int t_v;
        int rd0;
        int n;
        int first_v;
        int last_v;
        logic [W-1:0] d;

        // Reset values
        do_reset();
        check("rst_rd_en", 32'(rd_en_o), 0);
        check("rst_valid", 32'(m_valid_o), 0);
        check("rst_data", 32'(m_data_o), 0);
        check("rst_last", 32'(m_last_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_bursts", 32'(burst_cnt_o), 0);

        // Single word: valid exactly two cycles after the read
        fifo_q.push_back(4'hA);
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        rd0 = rd_pulses;
        t_rd = -1;
        t_v = -1;
        d = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_en_o && t_rd < 0) t_rd = i;
            if (m_valid_o && t_v < 0) begin
                t_v = i;
                d = m_data_o;
            end
        end
        check("single_seen", 32'(t_v >= 0 && t_rd >= 0), 1);
        check("single_latency", 32'(t_v - t_rd), 2);
        check("single_data", 32'(d), 32'h0A);
        check("single_reads", 32'(rd_pulses - rd0), 1);
        check("single_busy", 32'(busy_o), 0);

        // Streaming: 8 words back to back, two bursts
        do_reset();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        n = 0;
        first_v = -1;
        last_v = -1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (m_valid_o) begin
                n++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        check("stream_valid_cycles", 32'(n), 8);
        check("stream_no_gaps", 32'(last_v - first_v), 7);
        check("stream_last_count", 32'(lastw_q.size()), 2);
        if (lastw_q.size() == 2) begin
            check("stream_last0", 32'(lastw_q[0]), 32'h4);
            check("stream_last1", 32'(lastw_q[1]), 32'h8);
        end
        check("stream_bursts", 32'(burst_cnt_o), 2);

        // Backpressure: two reads outstanding, then in-order release at full rate
        do_reset();
        for (int i = 1; i <= 12; i++) fifo_q.push_back(W'(i));
        enable_i = 1'b1;
        rd0 = rd_pulses;
        for (int i = 0; i < 10; i++) tick();
        check("bp_reads", 32'(rd_pulses - rd0), 2);
        check("bp_valid", 32'(m_valid_o), 1);
        check("bp_head", 32'(m_data_o), 32'h1);
        m_ready_i = 1'b1;
        wait_dlv(12, 40, n);
        check("bp_release_cycles", 32'(n), 12);
        for (int i = 0; i < dlv_q.size(); i++) check("bp_order", 32'(dlv_q[i]), 32'(i + 1));

        // Empty toggling every cycle
        do_reset();
        toggle_mode = 1'b1;
        for (int i = 0; i < 6; i++) fifo_q.push_back(W'(9 - i));
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        wait_dlv(6, 60, n);
        for (int i = 0; i < dlv_q.size(); i++) check("empty_order", 32'(dlv_q[i]), 32'(9 - i));
        toggle_mode = 1'b0;

        // Enable drop with two words outstanding
        do_reset();
        for (int i = 0; i < 6; i++) fifo_q.push_back(W'(i + 3));
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        rd0 = rd_pulses;
        n = 0;
        while (rd_pulses - rd0 < 2 && n < 20) begin
            tick();
            n++;
        end
        enable_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("drop_reads", 32'(rd_pulses - rd0), 2);
        check("drop_delivered", 32'(dlv_q.size()), 2);
        if (dlv_q.size() == 2) check("drop_word1", 32'(dlv_q[1]), 32'h4);
        check("drop_valid", 32'(m_valid_o), 0);
        check("drop_busy", 32'(busy_o), 0);

        // Reset mid-burst: counter restarts
        do_reset();
        for (int i = 1; i <= 10; i++) fifo_q.push_back(W'(i));
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        wait_dlv(2, 20, n);
        rst_i = 1'b1;
        enable_i = 1'b0;
        tick();
        rst_i = 1'b0;
        check("mid_rst_valid", 32'(m_valid_o), 0);
        check("mid_rst_data", 32'(m_data_o), 0);
        check("mid_rst_last", 32'(m_last_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_rd_en", 32'(rd_en_o), 0);
        check("mid_rst_bursts", 32'(burst_cnt_o), 0);
        dlv_q.delete();
        lastw_q.delete();
        enable_i = 1'b1;
        wait_dlv(4, 30, n);
        check("mid_rst_last_count", 32'(lastw_q.size()), 1);
        if (lastw_q.size() == 1 && dlv_q.size() >= 4) check("mid_rst_last_word", 32'(lastw_q[0]), 32'(dlv_q[3]));
        enable_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_read_streamer.md
# fifo_read_streamer

Single-clock read-side consumer for the team's FIFOs. It drives the FIFO read port (`rd_en`/`rdata`/`empty`), absorbs the FIFO's one-cycle registered read latency in a 2-entry buffer, and presents the words as a valid/ready stream. The stream is grouped into bursts of `BURST_LEN` words, with a last-word marker. It sits in the read clock domain, between a FIFO and any downstream stream sink.

## Interface
- `WIDTH`, 4: data word width; must match the FIFO.
- `BURST_LEN`, 8: words per burst; legal range 1..255.
- `CNT_WIDTH`, 8: width of the burst and word counters.

- `rd_clk_i`  in  1  clock (the FIFO read clock).
- `rst_i`  in  1  reset; synchronous, active-high.
- `enable_i`  in  1  permit issuing new FIFO reads.
- `empty_i`  in  1  FIFO empty flag.
- `rdata_i`  in  WIDTH  FIFO read data; valid the cycle after `rd_en_o` is accepted.
- `rd_en_o`  out  1  FIFO read request.
- `m_valid_o`  out  1  stream word valid.
- `m_data_o`  out  WIDTH  stream word.
- `m_last_o`  out  1  word is the final word of a burst.
- `m_ready_i`  in  1  sink accepts the word.
- `busy_o`  out  1  a read is in flight, or the buffer holds data.
- `burst_cnt_o`  out  CNT_WIDTH  completed bursts; wraps modulo 2^CNT_WIDTH.

## Operation
- **State machine**
  - IDLE: `enable_i`=0. No new reads are issued. Buffered and in-flight words still drain.
  - RUN: `enable_i`=1. Reads are issued per the credit rule below.
  - IDLE->RUN when `enable_i`=1. RUN->IDLE when `enable_i`=0. Both transitions take effect the same cycle (combinational gating of `rd_en_o`).
- **Pop**
  - pop = `m_valid_o` & `m_ready_i`.
- **Credit rule**
  - `rd_en_o` = RUN & !`empty_i` & (occ + inflight − pop < 2).
  - occ is buffer occupancy (0..2). inflight is 1 if `rd_en_o` was high last cycle.
  - Buffer overflow is impossible by construction.
- **Capture**
  - When inflight=1, `rdata_i` is written into the buffer tail at the end of that cycle.
- **Ordering**
  - The buffer is FIFO-ordered. `m_data_o` is always the head entry; `m_valid_o` = (occ>0).
- **Words and bursts**
  - The word counter (0..BURST_LEN−1) increments on pop.
  - `m_last_o` = `m_valid_o` & (word counter == BURST_LEN−1).
  - On a pop with `m_last_o`=1, the word counter returns to 0 and `burst_cnt_o` increments.
  - The counter advances only on pop, so backpressure never changes it.
- **Stream rule**
  - Once `m_valid_o`=1, `m_data_o`, `m_last_o` and `m_valid_o` hold stable until pop.
- **Simultaneous capture and pop**
  - Occupancy stays unchanged. The head advances; the tail is written.
- **No underflow**
  - `rd_en_o` is never high while `empty_i`=1.
- `busy_o` = (occ>0) | inflight.

## Timing
- **Reset values** (`rst_i`=1 at a clock edge)
  - `rd_en_o`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `busy_o`=0, `burst_cnt_o`=0.
  - occ=0, inflight=0, word counter=0, state IDLE.
- **Reset mid-operation**
  - Buffered words and any in-flight word are discarded.
  - A FIFO read accepted in the reset cycle is lost; this is acceptable.
- **Latency**
  - `rd_en_o` high in cycle N → `rdata_i` valid in N+1 → `m_valid_o` high in N+2 (buffer was empty).
- **Throughput**
  - 1 word/cycle sustained when `m_ready_i`=1 and the FIFO is non-empty.
- **Stall and resume**
  - With `m_ready_i`=0, at most 2 reads are outstanding.
  - After `m_ready_i` rises, a pop occurs that cycle. A new read issues in the same cycle if occ + inflight − pop < 2.
- **`enable_i` deassertion**
  - Drop in cycle N → no `rd_en_o` in cycle N or later.
  - In-flight and buffered words (≤2) still appear on the stream.

## Structure
- **Shared package `fifo_stream_pkg`**
  - State enum (IDLE, RUN).
  - Constant `SKID_DEPTH`=2.
- **One sub-module, `skid_buf2`**
  - 2-entry register buffer with push, pop, occ, head outputs.
  - Reusable for other latency-absorbing stream stages.
- **Top level**
  - Credit logic, burst counters and state are instantiated here.

## Test plan
- **Single word:** reset, FIFO holds 0xA, `enable_i`=1, `m_ready_i`=1 → `rd_en_o` high one cycle; `m_valid_o` high 2 cycles later with `m_data_o`=0xA; `busy_o` returns to 0.
- **Streaming burst:** `BURST_LEN`=4, FIFO holds 0x1..0x8, `m_ready_i`=1 → 8 consecutive valid cycles; `m_last_o` on 0x4 and 0x8; `burst_cnt_o`=2.
- **Backpressure:** `m_ready_i`=0 for 10 cycles with a full FIFO → exactly 2 `rd_en_o` pulses; data holds at the first word. On release, words arrive in order with no gaps or duplicates.
- **Empty boundary:** `empty_i` toggling every cycle → `rd_en_o` is never high while `empty_i`=1; the output sequence matches the written sequence.
- **Enable drop:** `enable_i` falls while 2 words are outstanding → both words delivered, then `m_valid_o`=0 and no further reads.
- **Reset mid-burst:** assert `rst_i` after 2 of 4 burst words → all outputs are zero the next cycle. After re-enable, the word counter restarts, so `m_last_o` appears on the 4th new word.
